// File: rtl/spi_cmd_receiver_if.sv
// Bundles the SPI pins, the issued-command side and the status flags of spi_cmd_receiver.
// slave is the receiver's view; master is the SPI master / system_controller side.
interface spi_cmd_receiver_if #(
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic             sclk;
  logic             cs_n;
  logic             mosi;
  logic             miso;
  logic [31:0]      cmd_data;
  logic             latch_data;
  logic [CNT_W-1:0] fifo_count;
  logic             overflow;
  logic             frame_error;
  logic             clear_flags;

  modport slave (
    input  sclk, cs_n, mosi, clear_flags,
    output miso, cmd_data, latch_data, fifo_count, overflow, frame_error
  );

  modport master (
    output sclk, cs_n, mosi, clear_flags,
    input  miso, cmd_data, latch_data, fifo_count, overflow, frame_error
  );
endinterface

// File: rtl/spi_cmd_receiver.sv
// Oversampled SPI (mode 0, MSB first) command receiver with a word FIFO and latch_data pulse issue.
// Define CMD_ECHO_EN to shift the last accepted word back out on miso during the next frame.
module spi_cmd_receiver #(
  parameter int unsigned FIFO_DEPTH        = 4,
  parameter int unsigned LATCH_HIGH_CYCLES = 2,
  parameter int unsigned LATCH_GAP_CYCLES  = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  spi_cmd_receiver_if.slave bus
);
  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CW   = AW + 1;
  localparam int unsigned PMAX = (LATCH_HIGH_CYCLES > LATCH_GAP_CYCLES) ? LATCH_HIGH_CYCLES
                                                                        : LATCH_GAP_CYCLES;
  localparam int unsigned PW   = (PMAX > 1) ? $clog2(PMAX) : 1;

  typedef enum logic [1:0] {S_IDLE, S_PULSE, S_GAP} state_e;

  // [0]/[1] form the synchronizer, [2] holds the previous synchronized value
  logic [2:0]  sclk_q, cs_q;
  logic [1:0]  mosi_q;
  logic        sclk_rise, cs_rise, cs_sync, mosi_sync;

  logic [31:0] shift_q, shift_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic        push_req, frame_set, full, push_ok, pop;

  logic [31:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic        overflow_q, overflow_d, frame_err_q, frame_err_d;

  state_e      state_q, state_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [31:0] cmd_q, cmd_d;
  logic        latch_q, latch_d;

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign cs_rise   = cs_q[1] & ~cs_q[2];
  assign cs_sync   = cs_q[1];
  assign mosi_sync = mosi_q[1];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sclk_q <= '0;
      cs_q   <= '1;
      mosi_q <= '0;
    end else begin
      sclk_q <= {sclk_q[1:0], bus.sclk};
      cs_q   <= {cs_q[1:0], bus.cs_n};
      mosi_q <= {mosi_q[0], bus.mosi};
    end
  end

  // cs_rise implies cs_sync=1, so it never coincides with a shift
  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    push_req  = 1'b0;
    frame_set = 1'b0;
    if (cs_rise) begin
      bit_cnt_d = '0;
      frame_set = (bit_cnt_q != '0);
    end else if (!cs_sync && sclk_rise) begin
      shift_d   = {shift_q[30:0], mosi_sync};
      bit_cnt_d = bit_cnt_q + 5'd1;
      push_req  = (bit_cnt_q == 5'd31);
    end
  end

  assign full        = (count_q == CW'(FIFO_DEPTH));
  assign push_ok     = push_req && !full;
  assign pop         = (state_q == S_IDLE) && (count_q != '0);
  assign count_d     = count_q + CW'(push_ok) - CW'(pop);
  assign overflow_d  = (push_req && full) | (overflow_q & ~bus.clear_flags);
  assign frame_err_d = frame_set | (frame_err_q & ~bus.clear_flags);

  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    cmd_d   = cmd_q;
    unique case (state_q)
      S_IDLE: begin
        if (pop) begin
          cmd_d   = mem_q[rd_ptr_q];
          pcnt_d  = PW'(LATCH_HIGH_CYCLES - 1);
          state_d = S_PULSE;
        end
      end
      S_PULSE: begin
        if (pcnt_q == '0) begin
          pcnt_d  = PW'(LATCH_GAP_CYCLES - 1);
          state_d = S_GAP;
        end else begin
          pcnt_d = pcnt_q - PW'(1);
        end
      end
      S_GAP: begin
        if (pcnt_q == '0) state_d = S_IDLE;
        else              pcnt_d  = pcnt_q - PW'(1);
      end
      default: state_d = S_IDLE;
    endcase
    latch_d = (state_d == S_PULSE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
      state_q     <= S_IDLE;
      pcnt_q      <= '0;
      cmd_q       <= '0;
      latch_q     <= 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
      state_q     <= state_d;
      pcnt_q      <= pcnt_d;
      cmd_q       <= cmd_d;
      latch_q     <= latch_d;
      if (push_ok) begin
        mem_q[wr_ptr_q] <= shift_d;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

`ifdef CMD_ECHO_EN
  logic        sclk_fall, cs_fall;
  logic [31:0] echo_q, out_q;

  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign cs_fall   = ~cs_q[1] & cs_q[2];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      echo_q <= '0;
      out_q  <= '0;
    end else begin
      if (push_ok) echo_q <= shift_d;
      if (cs_fall)                      out_q <= echo_q;
      else if (!cs_sync && sclk_fall)   out_q <= {out_q[30:0], 1'b0};
    end
  end

  assign bus.miso = out_q[31] & ~cs_sync;
`else
  assign bus.miso = 1'b0;
`endif

  assign bus.cmd_data    = cmd_q;
  assign bus.latch_data  = latch_q;
  assign bus.fifo_count  = count_q;
  assign bus.overflow    = overflow_q;
  assign bus.frame_error = frame_err_q;
endmodule

// File: tb/tb_spi_cmd_receiver.sv
// Directed bench for spi_cmd_receiver: a default-timing instance plus a slow-pulse instance
// that keeps its issue FSM busy long enough for the FIFO to fill.
`timescale 1ns/1ps
module tb_spi_cmd_receiver;
  localparam int HALF = 40;  // sclk half period: sclk = clock/8

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic rst2_n = 1'b0;
  logic sclk = 1'b0;
  logic cs_n = 1'b1;
  logic mosi = 1'b0;
  logic clear_flags = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  spi_cmd_receiver_if #(.FIFO_DEPTH(4)) bus1 ();
  spi_cmd_receiver_if #(.FIFO_DEPTH(4)) bus2 ();

  assign bus1.sclk = sclk;  assign bus1.cs_n = cs_n;
  assign bus1.mosi = mosi;  assign bus1.clear_flags = clear_flags;
  assign bus2.sclk = sclk;  assign bus2.cs_n = cs_n;
  assign bus2.mosi = mosi;  assign bus2.clear_flags = clear_flags;

  spi_cmd_receiver #(.FIFO_DEPTH(4), .LATCH_HIGH_CYCLES(2), .LATCH_GAP_CYCLES(2)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus1.slave));

  spi_cmd_receiver #(.FIFO_DEPTH(4), .LATCH_HIGH_CYCLES(2000), .LATCH_GAP_CYCLES(2)) dut_slow (
    .clock(clock), .reset_n(rst2_n), .bus(bus2.slave));

  // Pulse monitor for the default instance
  int          cyc = 0;
  logic        prev_latch = 1'b0;
  logic        trk = 1'b0;
  logic [31:0] cur_word = '0;
  int          hi_len = 0;
  int          last_rise = 0;
  logic [2:0]  prev_cnt = '0;
  int          nz_cyc = 0;
  int          stab_err = 0;
  logic [31:0] q_words[$];
  int          q_rise[$];
  int          q_hilen[$];
  int          q_lat[$];

  always @(negedge clock) begin
    cyc++;
    if (!reset_n) begin
      prev_latch = 1'b0;
      trk        = 1'b0;
      prev_cnt   = '0;
    end else begin
      if (bus1.fifo_count != 3'd0 && prev_cnt == 3'd0) nz_cyc = cyc;
      if (bus1.latch_data && !prev_latch) begin
        q_words.push_back(bus1.cmd_data);
        q_rise.push_back(cyc);
        q_lat.push_back(cyc - nz_cyc);
        cur_word  = bus1.cmd_data;
        hi_len    = 1;
        last_rise = cyc;
        trk       = 1'b1;
      end else if (bus1.latch_data) begin
        hi_len++;
        if (bus1.cmd_data !== cur_word) stab_err++;
      end else begin
        if (prev_latch) q_hilen.push_back(hi_len);
        if (trk && (cyc - last_rise) < 4 && bus1.cmd_data !== cur_word) stab_err++;
      end
      prev_latch = bus1.latch_data;
      prev_cnt   = bus1.fifo_count;
    end
  end

  logic [31:0] q2[$];
  logic        prev2 = 1'b0;
  always @(negedge clock) begin
    if (!rst2_n) prev2 = 1'b0;
    else begin
      if (bus2.latch_data && !prev2) q2.push_back(bus2.cmd_data);
      prev2 = bus2.latch_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] getw(input int i);
    return (i < q_words.size()) ? q_words[i] : 32'hxxxx_xxxx;
  endfunction

  function automatic int geti(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic clr_q();
    q_words.delete(); q_rise.delete(); q_hilen.delete(); q_lat.delete(); q2.delete();
    stab_err = 0;
  endtask

  task automatic cs_low();
    @(negedge clock);
    cs_n = 1'b0;
    #HALF;
  endtask

  task automatic cs_high();
    #HALF cs_n = 1'b1;
    #HALF;
  endtask

  task automatic spi_bits(input logic [31:0] w, input int n, output logic [31:0] rx);
    rx = '0;
    for (int i = 0; i < n; i++) begin
      mosi = w[31-i];
      #HALF;
      rx = {rx[30:0], bus1.miso};
      sclk = 1'b1;
      #HALF sclk = 1'b0;
    end
  endtask

  task automatic wait_pulses(input int n, input int budget);
    int k = 0;
    while (q_hilen.size() < n && k < budget) begin
      @(negedge clock);
      k++;
    end
    chk("pulse_count", 32'(q_hilen.size()), 32'(n));
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rx;
    logic [31:0] ov_words[6];
    int k;

    repeat (3) @(negedge clock);
    chk("rst_latch", 32'(bus1.latch_data), 32'd0);
    chk("rst_cmd", bus1.cmd_data, 32'd0);
    chk("rst_count", 32'(bus1.fifo_count), 32'd0);
    chk("rst_overflow", 32'(bus1.overflow), 32'd0);
    chk("rst_frame_err", 32'(bus1.frame_error), 32'd0);
    chk("rst_miso", 32'(bus1.miso), 32'd0);
    reset_n = 1'b1;
    repeat (4) @(negedge clock);

    // Single word
    clr_q();
    cs_low(); spi_bits(32'hC800_0000, 32, rx); cs_high();
    wait_pulses(1, 200);
    chk("single_word", getw(0), 32'hC800_0000);
    chk("single_hilen", 32'(geti(q_hilen, 0)), 32'd2);
    chk("single_latency", 32'(geti(q_lat, 0)), 32'd1);
    chk("single_count", 32'(bus1.fifo_count), 32'd0);
    chk("single_flags", {30'd0, bus1.overflow, bus1.frame_error}, 32'd0);

    // Burst of three words in one frame
    clr_q();
    cs_low();
    spi_bits(32'h0001_0001, 32, rx);
    spi_bits(32'h4002_0002, 32, rx);
    spi_bits(32'h8003_0003, 32, rx);
    cs_high();
    wait_pulses(3, 300);
    chk("burst_w0", getw(0), 32'h0001_0001);
    chk("burst_w1", getw(1), 32'h4002_0002);
    chk("burst_w2", getw(2), 32'h8003_0003);
    chk("burst_hilen", 32'(geti(q_hilen, 0) + geti(q_hilen, 1) + geti(q_hilen, 2)), 32'd6);
    chk("burst_spacing01", 32'(geti(q_rise, 1) - geti(q_rise, 0) >= 5), 32'd1);
    chk("burst_spacing12", 32'(geti(q_rise, 2) - geti(q_rise, 1) >= 5), 32'd1);
    chk("burst_stable", 32'(stab_err), 32'd0);
    chk("burst_count", 32'(bus1.fifo_count), 32'd0);

    // Overflow on the slow-pulse instance: word 6 meets a full FIFO
    clr_q();
    @(negedge clock) rst2_n = 1'b1;
    repeat (2) @(negedge clock);
    for (int i = 0; i < 6; i++) ov_words[i] = 32'hA000_0001 + 32'(i);
    cs_low();
    for (int i = 0; i < 6; i++) spi_bits(ov_words[i], 32, rx);
    repeat (5) @(negedge clock);
    chk("ovf_count_full", 32'(bus2.fifo_count), 32'd4);
    chk("ovf_flag", 32'(bus2.overflow), 32'd1);
    chk("ovf_fast_inst_no_flag", 32'(bus1.overflow), 32'd0);
    cs_high();
    k = 0;
    while (q2.size() < 5 && k < 15000) begin
      @(negedge clock);
      k++;
    end
    chk("ovf_issued", 32'(q2.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      chk("ovf_word", (i < q2.size()) ? q2[i] : 32'hxxxx_xxxx, ov_words[i]);
    chk("ovf_drained", 32'(bus2.fifo_count), 32'd0);
    @(negedge clock) clear_flags = 1'b1;
    @(negedge clock) clear_flags = 1'b0;
    chk("ovf_cleared", 32'(bus2.overflow), 32'd0);
    rst2_n = 1'b0;

    // Frame error: cs_n rises after 17 bits
    clr_q();
    cs_low(); spi_bits(32'hFFFF_FFFF, 17, rx); cs_high();
    repeat (10) @(negedge clock);
    chk("ferr_flag", 32'(bus1.frame_error), 32'd1);
    chk("ferr_no_pulse", 32'(q_words.size()), 32'd0);
    chk("ferr_count", 32'(bus1.fifo_count), 32'd0);
    cs_low(); spi_bits(32'h1234_5678, 32, rx); cs_high();
    wait_pulses(1, 200);
    chk("ferr_next_word", getw(0), 32'h1234_5678);
    chk("ferr_sticky", 32'(bus1.frame_error), 32'd1);
    @(negedge clock) clear_flags = 1'b1;
    @(negedge clock) clear_flags = 1'b0;
    chk("ferr_cleared", 32'(bus1.frame_error), 32'd0);

    // Asynchronous reset in the middle of a pulse
    clr_q();
    cs_low(); spi_bits(32'hA5A5_0F0F, 32, rx);
    k = 0;
    while (!bus1.latch_data && k < 50) begin
      @(negedge clock);
      k++;
    end
    chk("arst_in_pulse", 32'(bus1.latch_data), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_latch", 32'(bus1.latch_data), 32'd0);
    chk("arst_count", 32'(bus1.fifo_count), 32'd0);
    chk("arst_cmd", bus1.cmd_data, 32'd0);
    @(negedge clock) reset_n = 1'b1;
    cs_high();
    clr_q();
    cs_low(); spi_bits(32'h0BAD_F00D, 32, rx); cs_high();
    wait_pulses(1, 200);
    chk("arst_new_word", getw(0), 32'h0BAD_F00D);
    chk("arst_new_hilen", 32'(geti(q_hilen, 0)), 32'd2);
    chk("arst_no_frame_err", 32'(bus1.frame_error), 32'd0);

`ifdef CMD_ECHO_EN
    cs_low(); spi_bits(32'hDEAD_BEEF, 32, rx); cs_high();
    chk("echo_prev_word", rx, 32'h0BAD_F00D);
    cs_low(); spi_bits(32'h0000_0000, 32, rx); cs_high();
    chk("echo_word", rx, 32'hDEAD_BEEF);
    chk("echo_idle_miso", 32'(bus1.miso), 32'd0);
`else
    cs_low(); spi_bits(32'hDEAD_BEEF, 32, rx); cs_high();
    chk("miso_tied_low", rx, 32'd0);
`endif

    repeat (20) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_cmd_receiver.md
Name: spi_cmd_receiver

Overview:
Upstream feeder for system_controller. Receives 32-bit command words from an external SPI master (mode 0, MSB first) and buffers them in a small FIFO. Presents each word on cmd_data with a clean latch_data pulse whose rising edge system_controller's edge detector turns into a one-cycle latch.
All SPI inputs are oversampled in the clock domain; there is no second clock.

Parameters:
FIFO_DEPTH, 4, number of buffered command words; power of 2, minimum 2.
LATCH_HIGH_CYCLES, 2, cycles latch_data is held high per word; minimum 1.
LATCH_GAP_CYCLES, 2, cycles latch_data is held low after each pulse before the next word; minimum 1.

Ports:
clock  input  1  system clock; must be at least 8x sclk frequency.
reset_n  input  1  asynchronous active-low reset.
sclk  input  1  SPI clock, asynchronous.
cs_n  input  1  SPI chip select, active low, asynchronous.
mosi  input  1  SPI data in, asynchronous.
miso  output  1  SPI data out.
cmd_data  output  32  command word to system_controller.
latch_data  output  1  word-valid pulse to system_controller.
fifo_count  output  clog2(FIFO_DEPTH)+1  words currently buffered.
overflow  output  1  sticky flag: a word was dropped because the FIFO was full.
frame_error  output  1  sticky flag: cs_n rose with a partial word in the shifter.
clear_flags  input  1  synchronous clear of overflow and frame_error.

Behaviour:
- Reset (async assert, sync release): all registers 0. cmd_data=0, latch_data=0, miso=0, fifo_count=0, overflow=0, frame_error=0; FIFO empty, bit counter 0, FSM in IDLE.
- Input sync: sclk, cs_n and mosi each pass through a 2-flop synchronizer plus one history flop.
  - sclk rise = sync 1 and prev 0; sclk fall likewise.
  - A cs_n synchronizer resets to 1 (deselected); all others reset to 0.
- Shifter, active only while synchronized cs_n=0:
  - On sclk rise: shift_reg <= {shift_reg[30:0], mosi_sync}; bit_cnt increments 0..31.
  - On the 32nd rise: the word {shift_reg[30:0], mosi_sync} is pushed into the FIFO and bit_cnt wraps to 0.
  - Multiple words per cs_n frame are allowed.
- cs_n rising:
  - Clears bit_cnt.
  - If bit_cnt != 0, the partial word is discarded and frame_error is set.
- FIFO push when full: the word is dropped, overflow is set, and FIFO contents are unchanged.
- Simultaneous push and pop: both occur; fifo_count is unchanged.
- clear_flags: clears both sticky flags. A flag set in the same cycle as clear_flags wins (stays 1).
- Issue FSM:
  - IDLE: if the FIFO is non-empty, pop the head into cmd_data and go to PULSE. latch_data=0.
  - PULSE: latch_data=1 for LATCH_HIGH_CYCLES cycles, then go to GAP.
  - GAP: latch_data=0 for LATCH_GAP_CYCLES cycles, then go to IDLE.
  - cmd_data changes only on the IDLE->PULSE transition. It is stable for the entire PULSE and GAP.
- Latency: the word is on cmd_data and latch_data is high 1 cycle after the FIFO becomes non-empty, when the FSM is in IDLE.
- Word spacing: minimum issue interval is 1+LATCH_HIGH_CYCLES+LATCH_GAP_CYCLES cycles (5 at defaults).
- Pulse counter: one shared down-counter, width sized for max(LATCH_HIGH_CYCLES, LATCH_GAP_CYCLES).
- FIFO: circular buffer. Read/write pointers are clog2(FIFO_DEPTH) bits with natural wrap; an extra bit on fifo_count distinguishes full from empty.
- Reset mid-operation: latch_data drops to 0 immediately (async); all buffered words are lost.

Optional Feature:
CMD_ECHO_EN:
- Defined:
  - An echo register captures each word at the moment it is pushed into the FIFO.
  - On each cs_n falling edge the echo register is loaded into an output shifter.
  - miso presents the output shifter's bit 31, updated on each sclk fall, so the master reads back the last accepted word during the next frame.
  - miso is 0 while cs_n=1.
- Undefined: miso is tied to 0 and the echo logic is absent.

Test Plan:
- Single word: send 0xC8000000 in one frame -> one latch_data pulse high exactly 2 cycles with cmd_data=0xC8000000; fifo_count returns to 0; flags stay 0.
- Burst of 3 words in one frame: send 0x00010001, 0x40020002, 0x80030003 -> three pulses in order, each pulse rising edge spaced at least 5 cycles apart, with cmd_data stable during each pulse and gap.
- Overflow: hold the issue FSM busy by sending 6 words back-to-back at the max sclk rate with FIFO_DEPTH=4 -> fifo_count peaks at 4, dropped words never appear, overflow=1; clear_flags pulse -> overflow=0.
- Frame error: raise cs_n after 17 bits -> frame_error=1, no pulse; the next full word 0x12345678 is issued correctly.
- Async reset during PULSE: reset_n=0 mid-pulse -> latch_data=0 in the same cycle, fifo_count=0, cmd_data=0; after release, a new word issues normally.
- CMD_ECHO_EN: send 0xDEADBEEF, then a second frame -> miso shifts out 0xDEADBEEF MSB-first on the second frame.
